colisao_nave: RTL

- Produces the `n_batidas` hit count that the ship block consumes to derive `vidas` and `perdeu`.
- Once per video frame, it scans the enemy-shot table through a registered read port. Each valid shot's box is tested against the ship box at (`x_nave`, `y_nave`).
- On a hit it counts the hit, clears that shot in the table, and opens an invulnerability window of N frames with a blink flag for the renderer.

---
 rtl/colisao_nave_if.sv | 30 +++
 rtl/colisao_nave.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/colisao_nave_if.sv
// Enemy-shot table port: registered read plus a clear strobe.
// The collision block is the master; the shot table is the slave.
interface colisao_nave_if #(
  parameter int IDX_W = 3
);
  logic [IDX_W-1:0] tiro_idx;
  logic [9:0]       tiro_x;
  logic [9:0]       tiro_y;
  logic             tiro_valido;
  logic             tiro_apagar;
  logic [IDX_W-1:0] tiro_apagar_idx;

  modport master (
    output tiro_idx,
    output tiro_apagar,
    output tiro_apagar_idx,
    input  tiro_x,
    input  tiro_y,
    input  tiro_valido
  );

  modport slave (
    input  tiro_idx,
    input  tiro_apagar,
    input  tiro_apagar_idx,
    output tiro_x,
    output tiro_y,
    output tiro_valido
  );
endinterface

// File: rtl/colisao_nave.sv
// Ship/enemy-shot collision: one table scan per frame, hit counter,
// and an invulnerability window with a blink phase for the sprite.
module colisao_nave #(
  parameter int N_TIROS        = 8,
  parameter int IDX_W          = 3,
  parameter int LARGURA        = 45,
  parameter int ALTURA         = 51,
  parameter int TIRO_L         = 4,
  parameter int TIRO_A         = 8,
  parameter int INVULN_QUADROS = 60,
  parameter int PISCA_DIV      = 8
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          reiniciarJogo,
  input  logic          pausa,
  input  logic          quadro,
  input  logic [9:0]    x_nave,
  input  logic [9:0]    y_nave,
  colisao_nave_if.master tiro,
  output logic [1:0]    n_batidas,
  output logic          invulneravel,
  output logic          piscar
);

  localparam int INV_W = $clog2(INVULN_QUADROS + 1);
  localparam int PIS_W = $clog2(PISCA_DIV + 1);

  localparam logic [IDX_W-1:0] ULT =
    IDX_W'(N_TIROS - 1);
  localparam logic [INV_W-1:0] INV_CARGA =
    INV_W'(INVULN_QUADROS);
  localparam logic [PIS_W-1:0] PIS_FIM =
    PIS_W'(PISCA_DIV - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    LE      = 2'd1,
    COMPARA = 2'd2,
    ACERTO  = 2'd3
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] apg_idx_q, apg_idx_d;
  logic [1:0]       nb_q, nb_d;
  logic             inv_q, inv_d;
  logic [INV_W-1:0] invc_q, invc_d;
  logic [PIS_W-1:0] pisc_q, pisc_d;
  logic             pis_q, pis_d;

  logic [10:0] sx, sy, nx, ny;
  logic        sobre;
  logic        acerto;
  logic        ultimo;
  logic        inicia;

  // 11-bit compare so ship/shot extents cannot wrap
  assign sx = {1'b0, tiro.tiro_x};
  assign sy = {1'b0, tiro.tiro_y};
  assign nx = {1'b0, x_nave};
  assign ny = {1'b0, y_nave};

  assign sobre =
    (sx < nx + 11'(LARGURA)) &&
    (sx + 11'(TIRO_L) > nx) &&
    (sy < ny + 11'(ALTURA)) &&
    (sy + 11'(TIRO_A) > ny);

  assign acerto = tiro.tiro_valido && sobre;
  assign ultimo = (idx_q == ULT);
  assign inicia = quadro && !inv_q &&
                  (nb_q != 2'd3);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      idx_q     <= '0;
      apg_idx_q <= '0;
      nb_q      <= '0;
      inv_q     <= 1'b0;
      invc_q    <= '0;
      pisc_q    <= '0;
      pis_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      apg_idx_q <= apg_idx_d;
      nb_q      <= nb_d;
      inv_q     <= inv_d;
      invc_q    <= invc_d;
      pisc_q    <= pisc_d;
      pis_q     <= pis_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    if (!pausa) begin
      unique case (estado_q)
        OCIOSO:
          if (inicia) estado_d = LE;
        LE:
          estado_d = COMPARA;
        COMPARA:
          if (acerto)      estado_d = ACERTO;
          else if (ultimo) estado_d = OCIOSO;
          else             estado_d = LE;
        ACERTO:
          estado_d = OCIOSO;
        default:
          estado_d = OCIOSO;
      endcase
    end
    if (reiniciarJogo) estado_d = OCIOSO;
  end

  always_comb begin
    idx_d     = idx_q;
    apg_idx_d = apg_idx_q;
    nb_d      = nb_q;
    inv_d     = inv_q;
    invc_d    = invc_q;
    pisc_d    = pisc_q;
    pis_d     = pis_q;

    if (!pausa) begin
      if (inv_q && quadro) begin
        if (invc_q <= 1) begin
          inv_d  = 1'b0;
          invc_d = '0;
          pisc_d = '0;
          pis_d  = 1'b0;
        end else begin
          invc_d = invc_q - 1'b1;
          if (pisc_q == PIS_FIM) begin
            pisc_d = '0;
            pis_d  = ~pis_q;
          end else begin
            pisc_d = pisc_q + 1'b1;
          end
        end
      end

      if (estado_q == OCIOSO && inicia)
        idx_d = '0;

      if (estado_q == COMPARA) begin
        if (acerto) begin
          // hit bookkeeping lands as ACERTO is entered
          apg_idx_d = idx_q;
          nb_d      = (nb_q == 2'd3) ? nb_q
                                     : nb_q + 1'b1;
          inv_d     = 1'b1;
          invc_d    = INV_CARGA;
          pisc_d    = '0;
          pis_d     = 1'b1;
        end else if (!ultimo) begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    if (reiniciarJogo) begin
      idx_d     = '0;
      apg_idx_d = '0;
      nb_d      = '0;
      inv_d     = 1'b0;
      invc_d    = '0;
      pisc_d    = '0;
      pis_d     = 1'b0;
    end
  end

  always_comb begin
    tiro.tiro_idx        = idx_q;
    tiro.tiro_apagar_idx = apg_idx_q;
    tiro.tiro_apagar     = (estado_q == ACERTO) &&
                           !pausa && !reiniciarJogo;
    n_batidas            = nb_q;
    invulneravel         = inv_q;
    piscar               = pis_q;
  end

endmodule
